mem_arbiter: RTL and testbench

//   Shares the single off-chip memory port between the I-cache and D-cache refill/writeback

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and defaults for the I/D memory port arbiter.
// Imported by the arbiter and anything that decodes its owner field.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF       = 28;
  localparam int unsigned DATA_W_DEF       = 128;
  localparam int unsigned MAX_D_STREAK_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_I  = 2'd1,
    ST_BUSY_D  = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the off-chip memory port between I-cache and D-cache.
// D has priority; a streak limit keeps I from starving.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        owner
);

  localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  state_e            state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic req_i, req_d;
  logic grant_i, grant_d;

  assign req_i = i_mem_read | i_mem_write;
  assign req_d = d_mem_read | d_mem_write;

  // I is forced only once D has used up its streak while I waited.
  assign grant_d = req_d & ~(req_i & (streak_q == STREAK_MAX));
  assign grant_i = req_i & ~grant_d;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_mem_ready = 1'b0;
    d_mem_ready = 1'b0;
    i_mem_rdata = '0;
    d_mem_rdata = '0;
    owner       = OWN_NONE;

    unique case (state_q)
      ST_IDLE: begin
        unique case (1'b1)
          grant_d: begin
            state_d     = ST_BUSY_D;
            mem_write_d = d_mem_write;
            mem_read_d  = d_mem_read & ~d_mem_write;
            mem_addr_d  = d_mem_addr;
            mem_wdata_d = d_mem_wdata;
            if (!req_i)
              streak_d = '0;
            else if (streak_q != STREAK_MAX)
              streak_d = streak_q + SW'(1);
          end
          grant_i: begin
            state_d     = ST_BUSY_I;
            mem_write_d = i_mem_write;
            mem_read_d  = i_mem_read & ~i_mem_write;
            mem_addr_d  = i_mem_addr;
            mem_wdata_d = i_mem_wdata;
            streak_d    = '0;
          end
          default: ;
        endcase
      end
      ST_BUSY_I: begin
        owner = OWN_I;
        if (mem_ready) begin
          i_mem_ready = 1'b1;
          i_mem_rdata = mem_rdata;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = ST_RELEASE;
        end
      end
      ST_BUSY_D: begin
        owner = OWN_D;
        if (mem_ready) begin
          d_mem_ready = 1'b1;
          d_mem_rdata = mem_rdata;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = ST_RELEASE;
        end
      end
      // One dead cycle lets the owner drop or swap its request.
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: cache agents, 3-cycle memory,
// directed scenarios in one initial block.
module tb_mem_arbiter;

  localparam int AW   = 28;
  localparam int DW   = 128;
  localparam int MAXS = 2;
  localparam int LAT  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_mem_read, i_mem_write;
  logic [AW-1:0] i_mem_addr;
  logic [DW-1:0] i_mem_wdata, i_mem_rdata;
  logic          i_mem_ready;
  logic          d_mem_read, d_mem_write;
  logic [AW-1:0] d_mem_addr;
  logic [DW-1:0] d_mem_wdata, d_mem_rdata;
  logic          d_mem_ready;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic [1:0]    owner;

  logic          mr_q;
  logic          inj;
  int            cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
  } req_t;

  typedef struct {
    bit            is_d;
    bit            wr;
    logic [AW-1:0] addr;
  } exp_t;

  req_t       iq[$];
  req_t       dq[$];
  exp_t       expq[$];
  logic [1:0] olog[$];
  bit         i_act, d_act;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .MAX_D_STREAK(MAXS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write),
    .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata),
    .i_mem_rdata(i_mem_rdata),
    .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read),
    .d_mem_write(d_mem_write),
    .d_mem_addr(d_mem_addr),
    .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata),
    .d_mem_ready(d_mem_ready),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .owner(owner)
  );

  function automatic logic [DW-1:0] line(input logic [AW-1:0] a);
    return {32'hDEADBEEF, 68'h0, a};
  endfunction

  function automatic logic [DW-1:0] wline(input logic [AW-1:0] a);
    return {32'hCAFEF00D, 68'h0, a};
  endfunction

  // Memory: fixed latency, one-cycle ready pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mr_q      <= 1'b0;
      cnt       <= 0;
      mem_rdata <= '0;
    end else begin
      mr_q <= 1'b0;
      if ((mem_read || mem_write) && !mr_q) begin
        if (cnt == LAT - 1) begin
          mr_q      <= 1'b1;
          mem_rdata <= line(mem_addr);
          cnt       <= 0;
        end else begin
          cnt <= cnt + 1;
        end
      end else begin
        cnt <= 0;
      end
    end
  end

  assign mem_ready = mr_q | inj;

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit is_d, input bit rd, input bit wr,
                       input logic [AW-1:0] a, input bit ex);
    req_t r;
    exp_t e;
    r.rd = rd; r.wr = wr; r.addr = a;
    if (is_d) dq.push_back(r);
    else      iq.push_back(r);
    if (ex) begin
      e.is_d = is_d; e.wr = wr; e.addr = a;
      expq.push_back(e);
    end
  endtask

  // Cache agents and scoreboard monitor, all at the falling edge.
  task automatic agents();
    exp_t e;
    req_t r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (i_mem_ready || d_mem_ready) begin
          chk("ready_pair", i_mem_ready & d_mem_ready, 0);
          chk("sb_nonempty", expq.size() != 0, 1);
          if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("who", d_mem_ready, e.is_d);
            chk("addr", mem_addr, e.addr);
            chk("wr", mem_write, e.wr);
            chk("rd", mem_read, !e.wr);
            chk("rdata", d_mem_ready ? d_mem_rdata : i_mem_rdata,
                line(e.addr));
            chk("idle_rdata", d_mem_ready ? i_mem_rdata : d_mem_rdata, 0);
            if (e.wr) chk("wdata", mem_wdata, wline(e.addr));
          end
          if (i_mem_ready) begin
            i_act = 0; i_mem_read = 0; i_mem_write = 0;
          end
          if (d_mem_ready) begin
            d_act = 0; d_mem_read = 0; d_mem_write = 0;
          end
        end
        if (!i_act && iq.size() != 0) begin
          r = iq.pop_front();
          i_mem_read = r.rd; i_mem_write = r.wr;
          i_mem_addr = r.addr; i_mem_wdata = wline(r.addr);
          i_act = 1;
        end
        if (!d_act && dq.size() != 0) begin
          r = dq.pop_front();
          d_mem_read = r.rd; d_mem_write = r.wr;
          d_mem_addr = r.addr; d_mem_wdata = wline(r.addr);
          d_act = 1;
        end
      end
      if (olog.size() == 0 ? owner != 2'b00 : owner != olog[$])
        olog.push_back(owner);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || i_act || d_act ||
            iq.size() != 0 || dq.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("drain", expq.size(), 0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    logic [1:0] oexp[4];
    int n;
    rst_n = 0; inj = 0;
    i_mem_read = 0; i_mem_write = 0; i_mem_addr = '0; i_mem_wdata = '0;
    d_mem_read = 0; d_mem_write = 0; d_mem_addr = '0; d_mem_wdata = '0;
    i_act = 0; d_act = 0;
    fork
      agents();
    join_none

    #1;
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_owner", owner, 0);
    chk("rst_i_ready", i_mem_ready, 0);
    chk("rst_d_ready", d_mem_ready, 0);
    chk("rst_i_rdata", i_mem_rdata, 0);
    chk("rst_d_rdata", d_mem_rdata, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;

    // Single I read.
    @(posedge clk); #2;
    issue(0, 1, 0, 28'h0000010, 1);
    @(posedge clk); #2;
    chk("t1_mem_read", mem_read, 1);
    chk("t1_mem_addr", mem_addr, 28'h0000010);
    chk("t1_owner", owner, 2'b01);
    drain();

    // Simultaneous I and D: D first.
    olog.delete();
    issue(1, 1, 0, 28'h0000020, 1);
    issue(0, 1, 0, 28'h0000030, 1);
    drain();
    oexp[0] = 2'b10; oexp[1] = 2'b00; oexp[2] = 2'b01; oexp[3] = 2'b00;
    chk("t2_olog_len", olog.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t2_owner%0d", k),
          k < olog.size() ? olog[k] : 2'b11, oexp[k]);

    // Dirty miss: D write-back then refill, I waiting.
    issue(1, 0, 1, 28'h0000100, 1);
    issue(1, 1, 0, 28'h0000200, 1);
    issue(0, 1, 0, 28'h0000600, 1);
    drain();

    // Continuous D with I pending: D,D,I,D,D,I.
    issue(1, 1, 0, 28'h0000400, 1);
    issue(1, 1, 0, 28'h0000401, 1);
    issue(0, 1, 0, 28'h0000500, 1);
    issue(1, 1, 0, 28'h0000402, 1);
    issue(1, 1, 0, 28'h0000403, 1);
    issue(0, 1, 0, 28'h0000501, 1);
    drain();

    // Stray mem_ready while idle.
    inj = 1;
    #1;
    chk("t5_i_ready", i_mem_ready, 0);
    chk("t5_d_ready", d_mem_ready, 0);
    chk("t5_owner", owner, 0);
    @(posedge clk); #2;
    inj = 0;
    chk("t5_owner_after", owner, 0);
    chk("t5_mem_read", mem_read, 0);
    issue(0, 1, 0, 28'h0000700, 1);
    @(posedge clk); #2;
    chk("t5_grant", owner, 2'b01);
    drain();

    // Reset mid BUSY_D with I pending.
    issue(1, 0, 1, 28'h0000300, 0);
    n = 0;
    while (owner != 2'b10 && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    chk("t6_busy_d", owner, 2'b10);
    issue(0, 1, 0, 28'h0000080, 1);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("t6_mem_write", mem_write, 0);
    chk("t6_mem_read", mem_read, 0);
    chk("t6_owner", owner, 0);
    chk("t6_d_ready", d_mem_ready, 0);
    chk("t6_i_ready", i_mem_ready, 0);
    dq.delete();
    d_act = 0; d_mem_read = 0; d_mem_write = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk); #2;
    chk("t6_post_owner", owner, 2'b01);
    chk("t6_post_addr", mem_addr, 28'h0000080);
    chk("t6_post_read", mem_read, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
